npp_vc_egress_arbiter: RTL and testbench

NPP_VC_EGRESS_ARBITER -- requirements
Module: npp_vc_egress_arbiter

---
 rtl/npp_arb_pkg.sv | 15 +
 rtl/npp_vc_credit_ctr.sv | 40 ++++
 rtl/npp_vc_egress_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_npp_vc_egress_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npp_arb_pkg.sv
// Shared constants and state encoding for the NPP VC egress arbiter.
package npp_arb_pkg;

    localparam int FLIT_W = 182;
    localparam int NUM_VC = 8;
    localparam int VC_W   = 3;
    localparam int CRED_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/npp_vc_credit_ctr.sv
// One per-VC credit counter: clear, load to the NoC allowance, +1 on return,
// -1 on accept, saturating at INIT_CREDITS with a sticky overflow flag.
module npp_vc_credit_ctr
    import npp_arb_pkg::*;
#(
    parameter int INIT_CREDITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic              inc,
    input  logic              dec,
    output logic [CRED_W-1:0] count,
    output logic              ovf
);

    localparam logic [CRED_W-1:0] MAX_CRED = CRED_W'(INIT_CREDITS);

    // Counter update; accept and return in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= MAX_CRED;
        end else if (inc && !dec) begin
            if (count >= MAX_CRED) begin
                ovf <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/npp_vc_egress_arbiter.sv
// NPP VC egress arbiter: round-robin with wormhole lock over N_REQ requesters,
// credit-gated per target VC, one registered flit per cycle to the NoC.
// Optional build macro NPP_ARB_STATS_EN adds stat_flits / stat_stall counters.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | credits zero, no grants; wait for npp_credit_rdy
//   LOAD  | one cycle, every VC counter loaded with INIT_CREDITS
//   RUN   | arbitration active; credit_rdy low returns to IDLE
module npp_vc_egress_arbiter
    import npp_arb_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int INIT_CREDITS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*FLIT_W-1:0]   req_flit,
    input  logic [N_REQ*VC_W-1:0]     req_vc,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic [FLIT_W-1:0]         npp_flit,
    output logic [NUM_VC-1:0]         npp_valid,
    input  logic [NUM_VC-1:0]         npp_credit_return,
    input  logic                      npp_credit_rdy,
    output logic                      credit_ovf
`ifdef NPP_ARB_STATS_EN
    ,
    output logic [31:0]               stat_flits,
    output logic [31:0]               stat_stall
`endif
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e          state;
    logic [CRED_W-1:0]   credit [NUM_VC];
    logic [NUM_VC-1:0]   vc_ovf;
    logic [VC_W-1:0]     vc_a [N_REQ];
    logic [N_REQ-1:0]    eligible;
    logic                locked;
    logic [IDX_W-1:0]    lock_idx;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    cand;
    logic                grant_valid;
    logic [IDX_W-1:0]    grant_idx;
    logic                accept;
    logic [VC_W-1:0]     acc_vc;
    logic                acc_last;
    logic                drop;
    logic                ctr_clr;
    logic [NUM_VC-1:0]   ctr_inc;
    logic [NUM_VC-1:0]   ctr_dec;

    // A requester can be granted only if its target VC still holds a credit.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            vc_a[i]     = req_vc[i*VC_W +: VC_W];
            eligible[i] = req_valid[i] && (credit[vc_a[i]] != '0);
        end
    end

    // Locked requester keeps the port (stalling if out of credit); otherwise
    // search round-robin starting at rr_ptr.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (locked) begin
            grant_valid = eligible[lock_idx];
            grant_idx   = lock_idx;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
                if (!grant_valid && eligible[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    // Combinational one-hot ready, only while running.
    always_comb begin
        req_ready = '0;
        if ((state == RUN) && grant_valid) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept   = |req_ready;
    assign acc_vc   = vc_a[grant_idx];
    assign acc_last = req_last[grant_idx];
    assign drop     = (state == RUN) && !npp_credit_rdy;
    assign ctr_clr  = (state == IDLE) || drop;

    // Per-VC counter controls; returns only count while running.
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            ctr_inc[v] = (state == RUN) && npp_credit_return[v];
            ctr_dec[v] = accept && (acc_vc == VC_W'(v));
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_ctr
        npp_vc_credit_ctr #(
            .INIT_CREDITS (INIT_CREDITS)
        ) u_ctr (
            .clk   (clk),
            .rst   (rst),
            .clr   (ctr_clr),
            .load  (state == LOAD),
            .inc   (ctr_inc[v]),
            .dec   (ctr_dec[v]),
            .count (credit[v]),
            .ovf   (vc_ovf[v])
        );
    end

    assign credit_ovf = |vc_ovf;

    // Credit bring-up / tear-down sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (npp_credit_rdy) state <= LOAD;
                LOAD:    state <= RUN;
                RUN:     if (!npp_credit_rdy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Wormhole lock and round-robin pointer; the pointer only moves on a
    // packet boundary so a multi-flit packet does not skip a turn.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked   <= 1'b0;
            lock_idx <= '0;
            rr_ptr   <= '0;
        end else begin
            if (accept) begin
                if (acc_last) begin
                    locked <= 1'b0;
                    rr_ptr <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                end else begin
                    locked   <= 1'b1;
                    lock_idx <= grant_idx;
                end
            end
            if (drop) begin
                locked <= 1'b0;
            end
        end
    end

    // Registered egress: accepted flit appears the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            npp_valid <= '0;
            npp_flit  <= '0;
        end else if (accept) begin
            npp_valid <= NUM_VC'(1) << acc_vc;
            npp_flit  <= req_flit[grant_idx*FLIT_W +: FLIT_W];
        end else begin
            npp_valid <= '0;
        end
    end

`ifdef NPP_ARB_STATS_EN
    // Accepted-flit and stalled-cycle counters, free-running with wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_flits <= '0;
            stat_stall <= '0;
        end else begin
            if (accept) begin
                stat_flits <= stat_flits + 32'd1;
            end
            if ((state == RUN) && (|req_valid) && !accept) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_npp_vc_egress_arbiter.sv
// Self-checking bench for npp_vc_egress_arbiter (default build).
module tb_npp_vc_egress_arbiter;
    import npp_arb_pkg::*;

    localparam int N = 4;

    typedef struct packed {
        logic              last;
        logic [2:0]        vc;
        logic [FLIT_W-1:0] flit;
    } ent_t;

    typedef struct packed {
        logic [7:0]        valid;
        logic [FLIT_W-1:0] flit;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N-1:0]          req_valid = '0;
    logic [N*FLIT_W-1:0]   req_flit = '0;
    logic [N*VC_W-1:0]     req_vc = '0;
    logic [N-1:0]          req_last = '0;
    logic [N-1:0]          req_ready;
    logic [FLIT_W-1:0]     npp_flit;
    logic [NUM_VC-1:0]     npp_valid;
    logic [NUM_VC-1:0]     npp_credit_return = '0;
    logic                  npp_credit_rdy = 1'b0;
    logic                  credit_ovf;
`ifdef NPP_ARB_STATS_EN
    logic [31:0]           stat_flits;
    logic [31:0]           stat_stall;
`endif

    ent_t         rq [N][$];
    exp_t         exp_q [$];
    logic [N-1:0] acc_mask = '0;
    int           acc_cnt [N];
    int           checks = 0;
    int           failures = 0;
    int           seq_n = 0;

    always #5 clk = ~clk;

    npp_vc_egress_arbiter #(
        .N_REQ        (N),
        .INIT_CREDITS (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_flit          (req_flit),
        .req_vc            (req_vc),
        .req_last          (req_last),
        .req_ready         (req_ready),
        .npp_flit          (npp_flit),
        .npp_valid         (npp_valid),
        .npp_credit_return (npp_credit_return),
        .npp_credit_rdy    (npp_credit_rdy),
        .credit_ovf        (credit_ovf)
`ifdef NPP_ARB_STATS_EN
        ,
        .stat_flits        (stat_flits),
        .stat_stall        (stat_stall)
`endif
    );

    // Requester model: present queue heads, retire a head once it was accepted.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_mask[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            if (rq[i].size() > 0) begin
                req_valid[i]                 = 1'b1;
                req_flit[i*FLIT_W +: FLIT_W] = rq[i][0].flit;
                req_vc[i*VC_W +: VC_W]       = rq[i][0].vc;
                req_last[i]                  = rq[i][0].last;
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    end

    // Record which requester is accepted at the coming edge.
    always @(negedge clk) begin
        acc_mask = rst ? '0 : req_ready;
        for (int i = 0; i < N; i++) begin
            if (!rst && req_ready[i]) acc_cnt[i]++;
        end
    end

    // Scoreboard: every egress flit must match the next expected one.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && npp_valid != '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL egress_unexpected valid=%b flit=%h expected no flit", npp_valid, npp_flit);
            end else begin
                e = exp_q.pop_front();
                if (npp_valid !== e.valid || npp_flit !== e.flit) begin
                    failures++;
                    $display("FAIL egress_flit got valid=%b flit=%h want valid=%b flit=%h",
                             npp_valid, npp_flit, e.valid, e.flit);
                end
            end
        end
    end

    task automatic push(input int r, input logic [2:0] vc, input logic last, input bit expect_out);
        ent_t e;
        exp_t x;
        seq_n++;
        e.flit          = '0;
        e.flit[181:178] = 4'(r);
        e.flit[177:170] = 8'(seq_n);
        e.flit[63:32]   = $urandom;
        e.flit[31:0]    = $urandom;
        e.vc            = vc;
        e.last          = last;
        rq[r].push_back(e);
        if (expect_out) begin
            x.valid = 8'(1) << vc;
            x.flit  = e.flit;
            exp_q.push_back(x);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        npp_credit_rdy = 1'b0;
        npp_credit_return = '0;
        for (int i = 0; i < N; i++) rq[i].delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Leaves the DUT in RUN at a falling edge.
    task automatic reset_bringup();
        do_reset();
        npp_credit_rdy = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        npp_credit_rdy = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (npp_valid !== 8'h00) begin failures++; $display("FAIL reset_npp_valid got=%b want=0", npp_valid); end
        checks++;
        if (npp_flit !== '0) begin failures++; $display("FAIL reset_npp_flit got=%h want=0", npp_flit); end
        checks++;
        if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
        checks++;
        if (credit_ovf !== 1'b0) begin failures++; $display("FAIL reset_credit_ovf got=%b want=0", credit_ovf); end
        npp_credit_rdy = 1'b0;
    endtask

    task automatic test_bring_up();
        do_reset();
        push(0, 3'd0, 1'b1, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0000) begin failures++; $display("FAIL bringup_idle_ready cycle=%0d got=%b want=0000", c, req_ready); end
        end
        @(negedge clk);
        npp_credit_rdy = 1'b1;
        checks++;
        if (req_ready !== 4'b0000) begin failures++; $display("FAIL bringup_rdy_cycle_ready got=%b want=0000", req_ready); end
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin failures++; $display("FAIL bringup_load_ready got=%b want=0000", req_ready); end
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin failures++; $display("FAIL bringup_run_ready got=%b want=0001", req_ready); end
        @(negedge clk);
        checks++;
        if (npp_valid !== 8'h01) begin failures++; $display("FAIL bringup_latency got=%b want=00000001", npp_valid); end
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL bringup_drain pending=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_exhaustion();
        int base;
        reset_bringup();
        base = acc_cnt[0];
        for (int p = 0; p < 10; p++) push(0, 3'd2, 1'b1, 1'b1);
        repeat (14) @(negedge clk);
        checks++;
        if (acc_cnt[0] - base != 8) begin failures++; $display("FAIL exhaust_count got=%0d want=8", acc_cnt[0] - base); end
        checks++;
        if (req_ready[0] !== 1'b0) begin failures++; $display("FAIL exhaust_ready_low got=%b want=0", req_ready[0]); end
        npp_credit_return = 8'b0000_0100;
        @(negedge clk);
        npp_credit_return = '0;
        repeat (4) @(negedge clk);
        checks++;
        if (acc_cnt[0] - base != 9) begin failures++; $display("FAIL exhaust_one_return got=%0d want=9", acc_cnt[0] - base); end
        checks++;
        if (req_ready[0] !== 1'b0) begin failures++; $display("FAIL exhaust_ready_after_return got=%b want=0", req_ready[0]); end
        npp_credit_return = 8'b0000_0100;
        @(negedge clk);
        npp_credit_return = '0;
        repeat (4) @(negedge clk);
        checks++;
        if (acc_cnt[0] - base != 10) begin failures++; $display("FAIL exhaust_second_return got=%0d want=10", acc_cnt[0] - base); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL exhaust_drain pending=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_round_robin();
        logic [3:0] order [5];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset_bringup();
        push(0, 3'd0, 1'b1, 1'b1);
        push(1, 3'd1, 1'b1, 1'b1);
        push(2, 3'd2, 1'b1, 1'b1);
        push(3, 3'd3, 1'b1, 1'b1);
        push(0, 3'd0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== order[k]) begin failures++; $display("FAIL rr_grant step=%0d got=%b want=%b", k, req_ready, order[k]); end
            if (k == 0) begin
                checks++;
                if (npp_valid !== 8'h00) begin failures++; $display("FAIL rr_no_early_valid got=%b want=0", npp_valid); end
            end
            if (k == 1) begin
                checks++;
                if (npp_valid !== 8'h01) begin failures++; $display("FAIL rr_latency got=%b want=00000001", npp_valid); end
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL rr_drain pending=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_wormhole();
        logic [3:0] order [5];
        order = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0001};
        reset_bringup();
        push(0, 3'd0, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin failures++; $display("FAIL worm_first got=%b want=0001", req_ready); end
        push(1, 3'd1, 1'b0, 1'b1);
        push(1, 3'd1, 1'b0, 1'b1);
        push(1, 3'd1, 1'b1, 1'b1);
        push(2, 3'd2, 1'b1, 1'b1);
        push(0, 3'd0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== order[k]) begin failures++; $display("FAIL worm_grant step=%0d got=%b want=%b", k, req_ready, order[k]); end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL worm_drain pending=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        int base;
        reset_bringup();
        checks++;
        if (credit_ovf !== 1'b0) begin failures++; $display("FAIL ovf_initial got=%b want=0", credit_ovf); end
        npp_credit_return = 8'b0000_0001;
        @(negedge clk);
        npp_credit_return = '0;
        checks++;
        if (credit_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b want=1", credit_ovf); end
        base = acc_cnt[3];
        for (int p = 0; p < 10; p++) push(3, 3'd0, 1'b1, p < 9);
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin failures++; $display("FAIL ovf_stream_ready got=%b want=1000", req_ready); end
        npp_credit_return = 8'b0000_0001;
        @(negedge clk);
        npp_credit_return = '0;
        repeat (14) @(negedge clk);
        checks++;
        if (acc_cnt[3] - base != 9) begin failures++; $display("FAIL ovf_simul_count got=%0d want=9", acc_cnt[3] - base); end
        checks++;
        if (credit_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b want=1", credit_ovf); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL ovf_drain pending=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_credit_drop();
        int base;
        reset_bringup();
        checks++;
        if (credit_ovf !== 1'b0) begin failures++; $display("FAIL drop_ovf_cleared got=%b want=0", credit_ovf); end
        base = acc_cnt[1];
        push(1, 3'd4, 1'b0, 1'b1);
        push(1, 3'd4, 1'b0, 1'b1);
        push(1, 3'd4, 1'b1, 1'b1);
        for (int p = 0; p < 7; p++) push(1, 3'd4, 1'b1, p < 6);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin failures++; $display("FAIL drop_first got=%b want=0010", req_ready); end
        npp_credit_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin failures++; $display("FAIL drop_idle_ready got=%b want=0000", req_ready); end
        checks++;
        if (npp_valid !== 8'h10) begin failures++; $display("FAIL drop_inflight got=%b want=00010000", npp_valid); end
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin failures++; $display("FAIL drop_idle_hold got=%b want=0000", req_ready); end
        npp_credit_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin failures++; $display("FAIL drop_load_ready got=%b want=0000", req_ready); end
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin failures++; $display("FAIL drop_resume got=%b want=0010", req_ready); end
        repeat (12) @(negedge clk);
        checks++;
        if (acc_cnt[1] - base != 9) begin failures++; $display("FAIL drop_reload_count got=%0d want=9", acc_cnt[1] - base); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL drop_drain pending=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_packet();
        reset_bringup();
        push(0, 3'd0, 1'b0, 1'b0);
        push(0, 3'd0, 1'b0, 1'b0);
        push(0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin failures++; $display("FAIL midrst_grant got=%b want=0001", req_ready); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (npp_valid !== 8'h00) begin failures++; $display("FAIL midrst_flit_dropped got=%b want=0", npp_valid); end
        checks++;
        if (req_ready !== 4'b0000) begin failures++; $display("FAIL midrst_ready got=%b want=0000", req_ready); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_bring_up();
        test_exhaustion();
        test_round_robin();
        test_wormhole();
        test_overflow();
        test_credit_drop();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
